// File: rtl/page_walker_pkg.sv
// -----------------------------------------------------------------------------
// page_walker_pkg
//   Shared definitions for the two-level page-table walker: FSM state encoding,
//   PTE flag bit positions and the width of one level's table index.
// -----------------------------------------------------------------------------
package page_walker_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_L1_REQ  = 3'd1,
      S_L1_WAIT = 3'd2,
      S_L2_REQ  = 3'd3,
      S_L2_WAIT = 3'd4,
      S_DONE    = 3'd5,
      S_FAULT   = 3'd6
   } state_t;

   // PTE flag bits; the PPN field starts at the page-offset width (SPAGE).
   localparam int PTE_V    = 0;
   localparam int PTE_LEAF = 1;

   // Each level indexes a table of 2**IDX_W entries of 4 bytes.
   localparam int IDX_W      = 10;
   localparam int PTE_SHIFT  = 2;

endpackage : page_walker_pkg

// File: rtl/page_walker_ptw_timer.sv
// -----------------------------------------------------------------------------
// ptw_timer
//   Wait counter for the walker's *_WAIT states.
//   clk     : clock
//   rst     : synchronous active-high reset
//   clear   : zero the counter (asserted on entry to a wait state)
//   enable  : count one cycle spent waiting without read data
//   expired : this waiting cycle is the one that brings the count to TIMEOUT
// -----------------------------------------------------------------------------
module ptw_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the values from before the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   // Flagged one cycle early: the FSM must leave on the same edge at which
   // the count would reach TIMEOUT, unless read data shows up that cycle.
   assign expired = (count == CW'(TIMEOUT - 1));

endmodule : ptw_timer

// File: rtl/page_walker.sv
// -----------------------------------------------------------------------------
// page_walker
//   Two-level hardware page-table walker serving TLB misses.
//   clk, rst          : clock, synchronous active-high reset
//   miss, va, pcid    : walk request (accepted only when idle)
//   ptbr              : root page-table base, 4 KiB aligned
//   flush             : abort any walk, nothing inserted
//   mem_req/mem_addr  : PTE read request, held until mem_gnt
//   mem_gnt           : request accepted this cycle
//   mem_rvalid/rdata  : PTE read data
//   insert, ins_*     : one-cycle TLB fill pulse with the translation
//   fault             : one-cycle walk-failure pulse
//   busy              : walker not idle
// -----------------------------------------------------------------------------
module page_walker
   import page_walker_pkg::*;
#(
   parameter int SADDR   = 32,
   parameter int SPAGE   = 12,
   parameter int SPCID   = 12,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             miss,
   input  logic [SADDR-1:0] va,
   input  logic [SPCID-1:0] pcid,
   input  logic [SADDR-1:0] ptbr,
   input  logic             flush,
   output logic             mem_req,
   output logic [SADDR-1:0] mem_addr,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [SADDR-1:0] mem_rdata,
   output logic             insert,
   output logic [SADDR-1:0] ins_va,
   output logic [SADDR-1:0] ins_pa,
   output logic [SPCID-1:0] ins_pcid,
   output logic             fault,
   output logic             busy
);

   localparam int SUPER = SPAGE + IDX_W;   // superpage offset width

   state_t state, state_nx;

   logic [SADDR-1:0]       va_q, ptbr_q, pa_q;
   logic [SPCID-1:0]       pcid_q;
   logic [SADDR-SPAGE-1:0] l2_base_q;

   logic tmr_clear, tmr_en, tmr_expired;
   logic start;

   logic [SADDR-1:0] l1_off, l2_off, l1_addr, l2_addr;

   logic pte_v, pte_leaf, super_misaligned;
   logic unused_rdata;

   assign pte_v            = mem_rdata[PTE_V];
   assign pte_leaf         = mem_rdata[PTE_LEAF];
   assign super_misaligned = |mem_rdata[SUPER-1:SPAGE];
   assign unused_rdata     = ^mem_rdata[SPAGE-1:PTE_LEAF+1];

   // Table offsets: index * 4, zero-extended; sums wrap modulo 2**SADDR.
   assign l1_off  = {{(SADDR-IDX_W-PTE_SHIFT){1'b0}}, va_q[SUPER +: IDX_W], {PTE_SHIFT{1'b0}}};
   assign l2_off  = {{(SADDR-IDX_W-PTE_SHIFT){1'b0}}, va_q[SPAGE +: IDX_W], {PTE_SHIFT{1'b0}}};
   assign l1_addr = ptbr_q + l1_off;
   assign l2_addr = {l2_base_q, {SPAGE{1'b0}}} + l2_off;

   assign start = (state == S_IDLE) && miss && !flush;

   ptw_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nx  = state;
      tmr_clear = 1'b0;
      tmr_en    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_nx = S_L1_REQ;
         end
         S_L1_REQ: begin
            if (mem_gnt) begin
               state_nx  = S_L1_WAIT;
               tmr_clear = 1'b1;
            end
         end
         S_L1_WAIT: begin
            if (mem_rvalid) begin
               if (!pte_v)                  state_nx = S_FAULT;
               else if (!pte_leaf)          state_nx = S_L2_REQ;
               else if (super_misaligned)   state_nx = S_FAULT;
               else                         state_nx = S_DONE;
            end else begin
               tmr_en = 1'b1;
               if (tmr_expired) state_nx = S_FAULT;
            end
         end
         S_L2_REQ: begin
            if (mem_gnt) begin
               state_nx  = S_L2_WAIT;
               tmr_clear = 1'b1;
            end
         end
         S_L2_WAIT: begin
            // LEAF is not meaningful at the last level.
            if (mem_rvalid) begin
               state_nx = pte_v ? S_DONE : S_FAULT;
            end else begin
               tmr_en = 1'b1;
               if (tmr_expired) state_nx = S_FAULT;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         S_FAULT: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      // Abort overrides every transition; in IDLE it also blocks a new walk.
      if (flush) state_nx = S_IDLE;
   end

   // Walk context. Captured PTE data is only ever shown while in DONE, so
   // capturing on a faulting or flushed response is harmless.
   always_ff @(posedge clk) begin
      if (rst) begin
         va_q      <= '0;
         pcid_q    <= '0;
         ptbr_q    <= '0;
         l2_base_q <= '0;
         pa_q      <= '0;
      end else begin
         if (start) begin
            va_q   <= va;
            pcid_q <= pcid;
            ptbr_q <= ptbr;
         end
         if (state == S_L1_WAIT && mem_rvalid) begin
            l2_base_q <= mem_rdata[SADDR-1:SPAGE];
            pa_q      <= {mem_rdata[SADDR-1:SUPER], va_q[SUPER-1:0]};
         end
         if (state == S_L2_WAIT && mem_rvalid) begin
            pa_q <= {mem_rdata[SADDR-1:SPAGE], va_q[SPAGE-1:0]};
         end
      end
   end

   // Outputs are gated by rst directly so they read 0 for the whole reset
   // cycle, not just after the state register has been cleared.
   always_comb begin
      mem_req  = 1'b0;
      mem_addr = '0;
      insert   = 1'b0;
      fault    = 1'b0;
      busy     = 1'b0;
      ins_va   = '0;
      ins_pa   = '0;
      ins_pcid = '0;
      if (!rst) begin
         busy = (state != S_IDLE);
         unique case (state)
            S_L1_REQ: begin
               mem_req  = 1'b1;
               mem_addr = l1_addr;
            end
            S_L2_REQ: begin
               mem_req  = 1'b1;
               mem_addr = l2_addr;
            end
            S_DONE: begin
               insert   = 1'b1;
               ins_va   = va_q;
               ins_pa   = pa_q;
               ins_pcid = pcid_q;
            end
            S_FAULT: fault = 1'b1;
            default: ;
         endcase
      end
   end

endmodule : page_walker

// File: tb/tb_page_walker.sv
// -----------------------------------------------------------------------------
// tb_page_walker
//   Self-checking bench for page_walker: directed scenarios followed by random
//   walks over a sparse page-table memory, checked against a reference model.
// -----------------------------------------------------------------------------
module tb_page_walker;

   logic        clk = 1'b0;
   logic        rst, miss, flush, mem_gnt, mem_rvalid;
   logic [31:0] va, ptbr, mem_rdata;
   logic [11:0] pcid;
   logic        mem_req, insert, fault, busy;
   logic [31:0] mem_addr, ins_va, ins_pa;
   logic [11:0] ins_pcid;

   int n_assert = 0;
   int n_fail   = 0;
   int ins_cnt  = 0;
   int flt_cnt  = 0;

   logic [31:0] mem [logic [31:0]];

   always #5 clk = ~clk;

   page_walker dut (
      .clk        (clk),
      .rst        (rst),
      .miss       (miss),
      .va         (va),
      .pcid       (pcid),
      .ptbr       (ptbr),
      .flush      (flush),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .insert     (insert),
      .ins_va     (ins_va),
      .ins_pa     (ins_pa),
      .ins_pcid   (ins_pcid),
      .fault      (fault),
      .busy       (busy)
   );

   // Pulse counters: a one-cycle pulse adds exactly one.
   always @(posedge clk) begin
      if (insert) ins_cnt <= ins_cnt + 1;
      if (fault)  flt_cnt <= flt_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   // Reference walk: Sv32-like two-level lookup written with plain arithmetic.
   task automatic model(input logic [31:0] v, input logic [31:0] base,
                        output int nreads, output logic [31:0] a1,
                        output logic [31:0] a2, output bit ok,
                        output logic [31:0] pa);
      logic [31:0] p1, p2;
      a1 = base + (v / 32'h0040_0000) * 4;
      a2 = 32'h0;
      p1 = rd(a1);
      nreads = 1;
      ok = 1'b0;
      pa = 32'h0;
      if (p1 % 2 == 0) begin
         ok = 1'b0;
      end else if ((p1 / 2) % 2 == 1) begin
         if (((p1 / 32'h1000) % 1024) != 0) ok = 1'b0;
         else begin
            ok = 1'b1;
            pa = (p1 / 32'h0040_0000) * 32'h0040_0000 + (v % 32'h0040_0000);
         end
      end else begin
         nreads = 2;
         a2 = (p1 / 32'h1000) * 32'h1000 + ((v / 32'h1000) % 1024) * 4;
         p2 = rd(a2);
         if (p2 % 2 == 1) begin
            ok = 1'b1;
            pa = (p2 / 32'h1000) * 32'h1000 + (v % 32'h1000);
         end
      end
   endtask

   task automatic run_walk(input logic [31:0] v, input logic [11:0] p,
                           input logic [31:0] base, input int gnt_lat,
                           input int rv_lat, input bit chk_lat);
      int nreads, lat, n, i0, f0;
      logic [31:0] a1, a2, addr, pa;
      bit ok;
      model(v, base, nreads, a1, a2, ok, pa);
      i0 = ins_cnt;
      f0 = flt_cnt;
      miss = 1'b1; va = v; pcid = p; ptbr = base;
      tick;
      lat = 1;
      miss = 1'b0; va = $urandom; pcid = 12'($urandom); ptbr = $urandom & 32'hFFFF_F000;
      for (int i = 0; i < nreads; i++) begin
         addr = (i == 0) ? a1 : a2;
         n = 0;
         while (!mem_req && n < 20) begin tick; n++; lat++; end
         chk("mem_req", mem_req, 1);
         chk("mem_addr", mem_addr, addr);
         repeat (gnt_lat) begin tick; lat++; end
         if (gnt_lat > 0) chk("addr_hold", mem_addr, addr);
         mem_gnt = 1'b1;
         tick; lat++;
         mem_gnt = 1'b0;
         chk("req_in_wait", mem_req, 0);
         repeat (rv_lat) begin tick; lat++; end
         mem_rvalid = 1'b1; mem_rdata = rd(addr);
         tick; lat++;
         mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
      chk("insert", insert, ok);
      chk("fault", fault, !ok);
      if (ok) begin
         chk("ins_pa", ins_pa, pa);
         chk("ins_va", ins_va, v);
         chk("ins_pcid", ins_pcid, p);
      end
      if (chk_lat) chk("latency", lat, 5);
      tick;
      chk("busy_after", busy, 0);
      chk("insert_pulses", ins_cnt - i0, ok);
      chk("fault_pulses", flt_cnt - f0, !ok);
   endtask

   initial begin
      int n, i0, f0;
      logic [31:0] v, base, l1a, l2a, pte;
      int kind;

      rst = 1'b1; miss = 1'b0; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      va = '0; pcid = '0; ptbr = '0; mem_rdata = '0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_insert", insert, 0);
      chk("rst_fault", fault, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ins_pa", ins_pa, 0);
      rst = 1'b0;
      tick;

      // flush together with miss in IDLE: walk not started
      miss = 1'b1; flush = 1'b1; va = 32'h00403ABC; ptbr = 32'h0001_0000;
      tick;
      miss = 1'b0; flush = 1'b0;
      chk("flush_miss_busy", busy, 0);
      chk("flush_miss_req", mem_req, 0);

      // Two-level walk, minimum latency
      mem[32'h0001_0004] = 32'h0002_0001;
      mem[32'h0002_000C] = 32'h0ABC_D001;
      run_walk(32'h00403ABC, 12'h5A5, 32'h0001_0000, 0, 0, 1);

      // Aligned superpage: single read
      mem[32'h0001_0004] = 32'h0C00_0003;
      run_walk(32'h00403ABC, 12'h123, 32'h0001_0000, 1, 1, 0);

      // Misaligned superpage, then invalid level-2 PTE
      mem[32'h0001_0004] = 32'h0C00_1003;
      run_walk(32'h00403ABC, 12'h321, 32'h0001_0000, 0, 2, 0);
      mem[32'h0001_0004] = 32'h0002_0001;
      mem[32'h0002_000C] = 32'h0000_0000;
      run_walk(32'h00403ABC, 12'h321, 32'h0001_0000, 2, 0, 0);

      // Timeout: no read data for 255 cycles
      mem[32'h0001_0004] = 32'h0C00_0003;
      i0 = ins_cnt; f0 = flt_cnt;
      miss = 1'b1; va = 32'h00403ABC; ptbr = 32'h0001_0000;
      tick;
      miss = 1'b0;
      mem_gnt = 1'b1;
      tick;
      mem_gnt = 1'b0;
      n = 0;
      while (!fault && n < 400) begin tick; n++; end
      chk("timeout_cycles", n, 255);
      chk("timeout_fault", fault, 1);
      tick;
      chk("timeout_idle", busy, 0);
      chk("timeout_no_insert", ins_cnt - i0, 0);
      chk("timeout_one_fault", flt_cnt - f0, 1);

      // Data on the last waiting cycle still wins
      run_walk(32'h00403ABC, 12'h0AA, 32'h0001_0000, 0, 254, 0);

      // Second miss ignored mid-walk; flush in L2_WAIT; late response dropped
      mem[32'h0001_0004] = 32'h0002_0001;
      mem[32'h0002_000C] = 32'h0ABC_D001;
      i0 = ins_cnt; f0 = flt_cnt;
      miss = 1'b1; va = 32'h00403ABC; pcid = 12'h111; ptbr = 32'h0001_0000;
      tick;
      miss = 1'b0;
      mem_gnt = 1'b1;
      tick;
      mem_gnt = 1'b0;
      miss = 1'b1; va = 32'h1234_5678; pcid = 12'h222;
      tick;
      miss = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h0002_0001;
      tick;
      mem_rvalid = 1'b0;
      chk("ignored_miss_req", mem_req, 1);
      chk("ignored_miss_addr", mem_addr, 32'h0002_000C);
      mem_gnt = 1'b1;
      tick;
      mem_gnt = 1'b0;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk("flush_busy", busy, 0);
      mem_rvalid = 1'b1; mem_rdata = 32'h0ABC_D001;
      tick;
      mem_rvalid = 1'b0;
      chk("late_rvalid_insert", insert, 0);
      chk("late_rvalid_busy", busy, 0);
      tick;
      chk("flush_no_insert", ins_cnt - i0, 0);
      chk("flush_no_fault", flt_cnt - f0, 0);

      // rst during L1_REQ with mem_gnt low
      i0 = ins_cnt; f0 = flt_cnt;
      miss = 1'b1; va = 32'h00403ABC; ptbr = 32'h0001_0000;
      tick;
      miss = 1'b0;
      chk("pre_rst_req", mem_req, 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("post_rst_req", mem_req, 0);
      chk("post_rst_addr", mem_addr, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_ins_va", ins_va, 0);
      chk("post_rst_pulses", (ins_cnt - i0) + (flt_cnt - f0), 0);
      run_walk(32'h00403ABC, 12'h777, 32'h0001_0000, 0, 0, 1);

      // Random walks
      for (int it = 0; it < 24; it++) begin
         v    = $urandom;
         base = $urandom & 32'hFFFF_F000;
         l1a  = base + (v / 32'h0040_0000) * 4;
         kind = $urandom_range(0, 3);
         case (kind)
            0: mem[l1a] = $urandom & 32'hFFFF_FFFE;
            1: mem[l1a] = ($urandom & 32'hFFC0_0FFC) | 32'h3;
            2: mem[l1a] = ($urandom & 32'hFFC0_0FFC) | ($urandom_range(1, 1023) * 32'h1000) | 32'h3;
            default: begin
               pte = ($urandom & 32'hFFFF_FFFC) | 32'h1;
               mem[l1a] = pte;
               l2a = (pte / 32'h1000) * 32'h1000 + ((v / 32'h1000) % 1024) * 4;
               mem[l2a] = $urandom;
            end
         endcase
         run_walk(v, 12'($urandom), base, $urandom_range(0, 3), $urandom_range(0, 4), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_page_walker
